// File: rtl/sd_tx_pkg.sv
// Shared constants and enumerations for the SD TX word streamer.
package sd_tx_pkg;

  localparam int SD_WORD_W   = 32;
  localparam int SD_ADR_STEP = 4;

  typedef enum logic {
    SLICE_LSB_FIRST = 1'b0,
    SLICE_MSB_FIRST = 1'b1
  } slice_order_e;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_REQ,
    WB_DONE
  } wb_state_e;

endpackage

// File: rtl/sd_tx_word_streamer_if.sv
// Wishbone classic read bus between the streamer (master) and memory (slave).
interface sd_tx_word_streamer_if;
  import sd_tx_pkg::*;

  logic [SD_WORD_W-1:0] m_wb_adr_o;
  logic                 m_wb_we_o;
  logic [SD_WORD_W-1:0] m_wb_dat_i;
  logic                 m_wb_cyc_o;
  logic                 m_wb_stb_o;
  logic                 m_wb_ack_i;
  logic                 m_wb_err_i;

  modport master (
    output m_wb_adr_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o,
    input  m_wb_dat_i, m_wb_ack_i, m_wb_err_i
  );

  modport slave (
    input  m_wb_adr_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o,
    output m_wb_dat_i, m_wb_ack_i, m_wb_err_i
  );

endinterface

// File: rtl/sd_word_slicer.sv
// Cuts the head ring word into OUT_W-bit symbols and requests a pop after the last one.
module sd_word_slicer
  import sd_tx_pkg::*;
#(
  parameter int OUT_W     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic [SD_WORD_W-1:0] word_i,
  input  logic                 valid_i,
  input  logic                 ready_i,
  output logic [OUT_W-1:0]     sym_o,
  output logic                 wr_o,
  output logic                 pop_o
);

  localparam int NSLICE = SD_WORD_W / OUT_W;
  localparam int SW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam slice_order_e ORDER = slice_order_e'(MSB_FIRST);

  logic [SW-1:0]        idx_q, idx_d, pos;
  logic                 lastSlice;
  logic [SD_WORD_W-1:0] shifted;

  always_comb begin
    pos       = (ORDER == SLICE_MSB_FIRST) ? (SW'(NSLICE - 1) - idx_q) : idx_q;
    shifted   = word_i >> (32'(pos) * OUT_W);
    lastSlice = (idx_q == SW'(NSLICE - 1));
    wr_o      = valid_i & ready_i;
    pop_o     = wr_o & lastSlice;
    sym_o     = valid_i ? shifted[OUT_W-1:0] : '0;
    idx_d     = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (wr_o) begin
      idx_d = lastSlice ? '0 : idx_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/sd_tx_word_streamer.sv
// Wishbone block fetcher feeding an NBUF-deep word ring that is sliced into the SD TX FIFO.
module sd_tx_word_streamer
  import sd_tx_pkg::*;
#(
  parameter int OUT_W     = 4,
  parameter int NBUF      = 2,
  parameter int ADR_STEP  = SD_ADR_STEP,
  parameter int CNT_W     = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  sd_tx_word_streamer_if.master wb,
  input  logic                  en,
  input  logic [SD_WORD_W-1:0]  adr,
  input  logic [CNT_W-1:0]      blk_words,
  output logic [OUT_W-1:0]      fifo_din,
  output logic                  fifo_wr,
  input  logic                  fifo_full,
  output logic                  done,
  output logic                  bus_err
);

  localparam int PW = $clog2(NBUF);
  localparam int CW = PW + 1;

  wb_state_e            state_q, state_d;
  logic [CNT_W-1:0]     reqIdx_q, reqIdx_d, blkLen_q, blkLen_d, popCnt_q, popCnt_d, blkLenEff;
  logic [PW-1:0]        wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 started_q, done_q, done_d, busErr_q, busErr_d;
  logic                 inReq, push, errHit, canFetch, pop;
  logic [SD_WORD_W-1:0] ring_q [NBUF];

  assign wb.m_wb_cyc_o = (state_q == WB_REQ);
  assign wb.m_wb_stb_o = wb.m_wb_cyc_o;
  assign wb.m_wb_we_o  = 1'b0;
  assign wb.m_wb_adr_o = adr + 32'(ADR_STEP) * 32'(reqIdx_q);
  assign done          = done_q;
  assign bus_err       = busErr_q;

  // The first enabled cycle uses blk_words directly so a zero-length block finishes one edge later.
  always_comb begin
    blkLenEff = started_q ? blkLen_q : blk_words;
    inReq     = (state_q == WB_REQ) & en;
    push      = inReq & wb.m_wb_ack_i & ~wb.m_wb_err_i;
    errHit    = inReq & wb.m_wb_err_i;
    canFetch  = en & ~busErr_q & (reqIdx_q < blkLenEff) & (count_q < CW'(NBUF));

    state_d  = state_q;
    reqIdx_d = reqIdx_q;
    if (!en) begin
      state_d  = WB_IDLE;
      reqIdx_d = '0;
    end else begin
      unique case (state_q)
        WB_IDLE: begin
          if (canFetch) begin
            state_d = WB_REQ;
          end else if (busErr_q || reqIdx_q >= blkLenEff) begin
            state_d = WB_DONE;
          end
        end
        WB_REQ: begin
          if (errHit) begin
            state_d = WB_DONE;
          end else if (push) begin
            reqIdx_d = reqIdx_q + CNT_W'(1);
            state_d  = (reqIdx_q + CNT_W'(1) == blkLenEff) ? WB_DONE : WB_IDLE;
          end
        end
        WB_DONE: state_d = WB_DONE;
        default: state_d = WB_IDLE;
      endcase
    end
  end

  always_comb begin
    count_d  = '0;
    wrPtr_d  = '0;
    rdPtr_d  = '0;
    popCnt_d = '0;
    blkLen_d = '0;
    done_d   = 1'b0;
    busErr_d = 1'b0;
    if (en) begin
      count_d  = count_q + CW'(push) - CW'(pop);
      wrPtr_d  = wrPtr_q + PW'(push);
      rdPtr_d  = rdPtr_q + PW'(pop);
      popCnt_d = popCnt_q + CNT_W'(pop);
      blkLen_d = blkLenEff;
      busErr_d = busErr_q | errHit;
      done_d   = ~busErr_d & (done_q | (popCnt_d == blkLenEff));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WB_IDLE;
      reqIdx_q  <= '0;
      blkLen_q  <= '0;
      popCnt_q  <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      started_q <= 1'b0;
      done_q    <= 1'b0;
      busErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      reqIdx_q  <= reqIdx_d;
      blkLen_q  <= blkLen_d;
      popCnt_q  <= popCnt_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      started_q <= en;
      done_q    <= done_d;
      busErr_q  <= busErr_d;
    end
  end

  // Ring payload needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      ring_q[wrPtr_q] <= wb.m_wb_dat_i;
    end
  end

  sd_word_slicer #(
    .OUT_W     (OUT_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_slicer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (~en),
    .word_i  (ring_q[rdPtr_q]),
    .valid_i (en && (count_q != '0)),
    .ready_i (~fifo_full),
    .sym_o   (fifo_din),
    .wr_o    (fifo_wr),
    .pop_o   (pop)
  );

endmodule

// File: tb/tb_sd_tx_word_streamer.sv
// Directed bench: nibble streamer (DUT A, LSB first) and bit streamer (DUT B, MSB first).
module tb_sd_tx_word_streamer;
  import sd_tx_pkg::*;

  localparam int NBUF_A = 2;

  typedef struct {
    string name;
    int    blkWords;
    int    ackDelay;
    int    errRead;
    int    stallCycles;
    int    expSyms;
    bit    expDone;
    bit    expBusErr;
    int    expReads;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_tx_word_streamer_if wbA ();
  sd_tx_word_streamer_if wbB ();

  logic        enA, enB, wrA, wrB, fullA, fullB, doneA, doneB, errA, errB;
  logic [31:0] adrA, adrB;
  logic [15:0] blkA, blkB;
  logic [3:0]  dinA;
  logic [0:0]  dinB;

  sd_tx_word_streamer #(.OUT_W(4), .NBUF(NBUF_A), .MSB_FIRST(1'b0)) dutA (
    .clk(clk), .rst(rst), .wb(wbA), .en(enA), .adr(adrA), .blk_words(blkA),
    .fifo_din(dinA), .fifo_wr(wrA), .fifo_full(fullA), .done(doneA), .bus_err(errA)
  );

  sd_tx_word_streamer #(.OUT_W(1), .NBUF(2), .MSB_FIRST(1'b1)) dutB (
    .clk(clk), .rst(rst), .wb(wbB), .en(enB), .adr(adrB), .blk_words(blkB),
    .fifo_din(dinB), .fifo_wr(wrB), .fifo_full(fullB), .done(doneB), .bus_err(errB)
  );

  logic [31:0] memA [0:7];
  int          ackDelayA = 0, errReadA = -1, readCountA = 0, waitA = 0;
  bit          issuedA = 1'b0;
  logic [31:0] adrLogA [$];
  logic [3:0]  symA [$];
  int          violA = 0;

  int          readCountB = 0, cycSeenB = 0;
  logic [0:0]  symB [$];

  int compared = 0, failed = 0;
  int symBase, readBase;
  vec_t vecs [4];

  // Memory slave A: responds on the falling edge so the DUT samples a stable ack/err.
  always @(negedge clk) begin
    if (rst || !(wbA.m_wb_cyc_o && wbA.m_wb_stb_o)) begin
      wbA.m_wb_ack_i = 1'b0;
      wbA.m_wb_err_i = 1'b0;
      wbA.m_wb_dat_i = '0;
      waitA          = 0;
      issuedA        = 1'b0;
    end else if (!issuedA) begin
      if (waitA >= ackDelayA) begin
        adrLogA.push_back(wbA.m_wb_adr_o);
        if (readCountA == errReadA) begin
          wbA.m_wb_err_i = 1'b1;
        end else begin
          wbA.m_wb_ack_i = 1'b1;
          wbA.m_wb_dat_i = memA[wbA.m_wb_adr_o[4:2]];
        end
        readCountA++;
        issuedA = 1'b1;
      end else begin
        waitA++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst || !(wbB.m_wb_cyc_o && wbB.m_wb_stb_o) || wbB.m_wb_ack_i) begin
      wbB.m_wb_ack_i = 1'b0;
      wbB.m_wb_err_i = 1'b0;
      wbB.m_wb_dat_i = '0;
    end else begin
      wbB.m_wb_ack_i = 1'b1;
      wbB.m_wb_dat_i = 32'h8000_0001;
      readCountB++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (wrA) symA.push_back(dinA);
      if (wrA && fullA) violA++;
      if (wrB) symB.push_back(dinB);
      if (wbB.m_wb_cyc_o) cycSeenB++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [3:0] modelNibble(input int i);
    logic [31:0] w;
    w = memA[i / 8];
    return 4'((w >> (4 * (i % 8))) & 32'hF);
  endfunction

  task automatic applyStimulus(input vec_t t);
    bit stalled;
    stalled = 1'b0;
    enA   = 1'b0;
    fullA = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ackDelayA = t.ackDelay;
    errReadA  = (t.errRead >= 0) ? readCountA + t.errRead : -1;
    symBase   = symA.size();
    readBase  = readCountA;
    blkA      = 16'(t.blkWords);
    enA       = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (t.stallCycles > 0 && !stalled && (symA.size() - symBase) >= 8) begin
        stalled = 1'b1;
        fullA   = 1'b1;
        repeat (t.stallCycles) @(posedge clk);
        #1;
        checkOutput({t.name, "_stall_reads"}, 32'(readCountA - readBase), 32'(NBUF_A + 1));
        checkOutput({t.name, "_stall_cyc"}, 32'(wbA.m_wb_cyc_o), 32'd0);
        checkOutput({t.name, "_stall_syms"}, 32'(symA.size() - symBase), 32'd8);
        fullA = 1'b0;
      end
      if (doneA) break;
    end
  endtask

  task automatic checkScenario(input vec_t t);
    int bad;
    checkOutput({t.name, "_sym_count"}, 32'(symA.size() - symBase), 32'(t.expSyms));
    bad = 0;
    for (int i = 0; i < t.expSyms && (symBase + i) < symA.size(); i++)
      if (symA[symBase + i] !== modelNibble(i)) bad++;
    checkOutput({t.name, "_sym_order_errs"}, 32'(bad), 32'd0);
    checkOutput({t.name, "_done"}, 32'(doneA), 32'(t.expDone));
    checkOutput({t.name, "_bus_err"}, 32'(errA), 32'(t.expBusErr));
    checkOutput({t.name, "_reads"}, 32'(readCountA - readBase), 32'(t.expReads));
    bad = 0;
    for (int i = 0; i < t.expReads && (readBase + i) < adrLogA.size(); i++)
      if (adrLogA[readBase + i] !== 32'h1000 + 32'(4 * i)) bad++;
    checkOutput({t.name, "_adr_errs"}, 32'(bad), 32'd0);
    checkOutput({t.name, "_wr_while_full"}, 32'(violA), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    memA[0] = 32'h8765_4321; memA[1] = 32'hFEDC_BA98; memA[2] = 32'h1357_9BDF;
    memA[3] = 32'h0F1E_2D3C; memA[4] = 32'hA5A5_5A5A; memA[5] = '0;
    memA[6] = '0;            memA[7] = '0;
    vecs[0] = '{"basic",  3, 0, -1,  0, 24, 1'b1, 1'b0, 3};
    vecs[1] = '{"stall",  5, 0, -1, 50, 40, 1'b1, 1'b0, 5};
    vecs[2] = '{"slowack",3, 5, -1,  0, 24, 1'b1, 1'b0, 3};
    vecs[3] = '{"buserr", 3, 0,  1,  0,  8, 1'b0, 1'b1, 2};
    enA = 1'b0; enB = 1'b0; fullA = 1'b0; fullB = 1'b0;
    adrA = 32'h1000; adrB = 32'h2000; blkA = '0; blkB = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_cyc", 32'(wbA.m_wb_cyc_o), 32'd0);
    checkOutput("rst_stb", 32'(wbA.m_wb_stb_o), 32'd0);
    checkOutput("rst_we", 32'(wbA.m_wb_we_o), 32'd0);
    checkOutput("rst_fifo_wr", 32'(wrA), 32'd0);
    checkOutput("rst_fifo_din", 32'(dinA), 32'd0);
    checkOutput("rst_done", 32'(doneA), 32'd0);
    checkOutput("rst_bus_err", 32'(errA), 32'd0);

    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v]);
      checkScenario(vecs[v]);
    end

    // Abort a read that is still waiting for ack, then restart a one-word block.
    enA = 1'b0; errReadA = -1; ackDelayA = 20;
    repeat (2) @(posedge clk);
    #1 blkA = 16'd3; enA = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (wbA.m_wb_cyc_o) break;
    end
    checkOutput("abort_cyc_up", 32'(wbA.m_wb_cyc_o), 32'd1);
    repeat (2) @(posedge clk);
    #1 enA = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_cyc_down", 32'(wbA.m_wb_cyc_o), 32'd0);
    checkOutput("abort_fifo_wr", 32'(wrA), 32'd0);
    checkOutput("abort_done", 32'(doneA), 32'd0);
    repeat (3) @(posedge clk);
    #1 ackDelayA = 0; symBase = symA.size(); readBase = readCountA;
    blkA = 16'd1; enA = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (doneA) break;
    end
    checkOutput("restart_done", 32'(doneA), 32'd1);
    checkOutput("restart_reads", 32'(readCountA - readBase), 32'd1);
    checkOutput("restart_adr", (adrLogA.size() > readBase) ? adrLogA[readBase] : 32'hDEAD, 32'h1000);
    checkOutput("restart_syms", 32'(symA.size() - symBase), 32'd8);
    bad = 0;
    for (int i = 0; i < 8 && (symBase + i) < symA.size(); i++)
      if (symA[symBase + i] !== 4'(i + 1)) bad++;
    checkOutput("restart_nibbles_1_to_8", 32'(bad), 32'd0);
    enA = 1'b0;

    // Bit-serial MSB-first word, then a zero-length block.
    symBase = symB.size(); readBase = readCountB;
    blkB = 16'd1; enB = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (doneB) break;
    end
    checkOutput("msb_done", 32'(doneB), 32'd1);
    checkOutput("msb_reads", 32'(readCountB - readBase), 32'd1);
    checkOutput("msb_syms", 32'(symB.size() - symBase), 32'd32);
    bad = 0;
    for (int i = 0; i < 32 && (symBase + i) < symB.size(); i++)
      if (symB[symBase + i] !== ((i == 0 || i == 31) ? 1'b1 : 1'b0)) bad++;
    checkOutput("msb_bit_errs", 32'(bad), 32'd0);
    enB = 1'b0;
    repeat (2) @(posedge clk);
    #1 readBase = readCountB; symBase = cycSeenB;
    blkB = 16'd0; enB = 1'b1;
    checkOutput("zero_done_before_edge", 32'(doneB), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("zero_done_after_edge", 32'(doneB), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("zero_done_level", 32'(doneB), 32'd1);
    checkOutput("zero_reads", 32'(readCountB - readBase), 32'd0);
    checkOutput("zero_cyc_cycles", 32'(cycSeenB - symBase), 32'd0);
    enB = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
